// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register file write-port arbiter, writeback priority with loader starvation guard.
// Optional same-register coalescing enabled by defining RF_ARB_COALESCE_EN.
module rf_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_valid,
    input  logic [2:0] wb_reg,
    input  logic [7:0] wb_data,
    output logic       wb_ready,
    input  logic       dbg_valid,
    input  logic [2:0] dbg_reg,
    input  logic [7:0] dbg_data,
    output logic       dbg_ready,
    input  logic       clear_dirty,
    output logic       regwrite,
    output logic [2:0] write_reg,
    output logic [7:0] write_data,
    output logic [7:0] dirty,
    output logic       forced
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] cnt;
    logic       grant_wb;
    logic       grant_dbg;
    logic       dbg_accept;
    logic       coalesce;

    assign forced = (cnt == LIMIT) && dbg_valid;

`ifdef RF_ARB_COALESCE_EN
    // Same-register collision: WB data is newer, so the loader write is simply retired.
    assign coalesce = wb_valid && dbg_valid && !forced && (wb_reg == dbg_reg);
`else
    assign coalesce = 1'b0;
`endif

    assign wb_ready   = !forced;
    assign dbg_ready  = forced || !wb_valid || coalesce;
    assign grant_wb   = wb_valid && wb_ready;
    assign grant_dbg  = !grant_wb && dbg_valid && dbg_ready;
    assign dbg_accept = dbg_valid && dbg_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite   <= 1'b0;
            write_reg  <= 3'd0;
            write_data <= 8'd0;
        end else begin
            regwrite <= grant_wb || grant_dbg;
            if (grant_wb) begin
                write_reg  <= wb_reg;
                write_data <= wb_data;
            end else if (grant_dbg) begin
                write_reg  <= dbg_reg;
                write_data <= dbg_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (!dbg_valid || dbg_accept) begin
            cnt <= 4'd0;
        end else if (cnt < LIMIT) begin
            cnt <= cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dirty <= 8'd0;
        end else if (clear_dirty) begin
            dirty <= 8'd0;
        end else if (regwrite) begin
            dirty <= dirty | (8'd1 << write_reg);
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter.
module tb_rf_write_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wb_valid = 1'b0;
    logic [2:0] wb_reg = 3'd0;
    logic [7:0] wb_data = 8'd0;
    logic       wb_ready;
    logic       dbg_valid = 1'b0;
    logic [2:0] dbg_reg = 3'd0;
    logic [7:0] dbg_data = 8'd0;
    logic       dbg_ready;
    logic       clear_dirty = 1'b0;
    logic       regwrite;
    logic [2:0] write_reg;
    logic [7:0] write_data;
    logic [7:0] dirty;
    logic       forced;

    int compared = 0;
    int mismatched = 0;

    rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ready(wb_ready),
        .dbg_valid(dbg_valid), .dbg_reg(dbg_reg), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
        .clear_dirty(clear_dirty),
        .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
        .dirty(dirty), .forced(forced)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("rst_wb_ready", 32'(wb_ready), 32'd1);
        check("rst_forced", 32'(forced), 32'd0);
        check("rst_regwrite", 32'(regwrite), 32'd0);
        check("rst_write_reg", 32'(write_reg), 32'd0);
        check("rst_write_data", 32'(write_data), 32'd0);
        check("rst_dirty", 32'(dirty), 32'd0);
        #10 reset = 1'b0;
        tick();

        // single writeback write
        wb_valid = 1'b1; wb_reg = 3'd3; wb_data = 8'hA5;
        #1 check("t1_wb_ready", 32'(wb_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        check("t1_regwrite", 32'(regwrite), 32'd1);
        check("t1_write_reg", 32'(write_reg), 32'd3);
        check("t1_write_data", 32'(write_data), 32'hA5);
        tick();
        check("t1_idle_regwrite", 32'(regwrite), 32'd0);
        check("t1_hold_reg", 32'(write_reg), 32'd3);
        check("t1_dirty", 32'(dirty), 32'h08);

        // starvation: WB wins four cycles, loader forced on the fifth
        wb_valid = 1'b1; wb_reg = 3'd1; wb_data = 8'h10;
        dbg_valid = 1'b1; dbg_reg = 3'd2; dbg_data = 8'h3C;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check($sformatf("t2_forced_c%0d", c), 32'(forced), 32'd0);
            check($sformatf("t2_dbg_ready_c%0d", c), 32'(dbg_ready), 32'd0);
            tick();
            check($sformatf("t2_wr_reg_c%0d", c), 32'(write_reg), 32'd1);
        end
        #1;
        check("t2_forced_c5", 32'(forced), 32'd1);
        check("t2_wb_ready_c5", 32'(wb_ready), 32'd0);
        check("t2_dbg_ready_c5", 32'(dbg_ready), 32'd1);
        tick();
        dbg_valid = 1'b0;
        check("t2_dbg_regwrite", 32'(regwrite), 32'd1);
        check("t2_dbg_reg", 32'(write_reg), 32'd2);
        check("t2_dbg_data", 32'(write_data), 32'h3C);
        #1 check("t2_wb_ready_c6", 32'(wb_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        check("t2_wb_resume", 32'(write_reg), 32'd1);
        tick();
        tick();
        check("t2_dirty", 32'(dirty), 32'h0E);

        // loader drops while starved: counter must restart from zero
        wb_valid = 1'b1; dbg_valid = 1'b1;
        tick(); tick();
        dbg_valid = 1'b0;
        tick();
        check("t3_drop_no_dbg_grant", 32'(write_reg), 32'd1);
        dbg_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1 check($sformatf("t3_forced_c%0d", c), 32'(forced), 32'd0);
            tick();
        end
        #1 check("t3_forced_c5", 32'(forced), 32'd1);
        tick();
        wb_valid = 1'b0; dbg_valid = 1'b0;
        tick();

        // loader alone
        dbg_valid = 1'b1; dbg_reg = 3'd7; dbg_data = 8'hFF;
        #1;
        check("t4_dbg_ready", 32'(dbg_ready), 32'd1);
        check("t4_forced", 32'(forced), 32'd0);
        tick();
        dbg_valid = 1'b0;
        check("t4_regwrite", 32'(regwrite), 32'd1);
        check("t4_write_reg", 32'(write_reg), 32'd7);
        check("t4_write_data", 32'(write_data), 32'hFF);
        tick();

        // same-register collision
        wb_valid = 1'b1; wb_reg = 3'd5; wb_data = 8'h11;
        dbg_valid = 1'b1; dbg_reg = 3'd5; dbg_data = 8'h22;
        #1 check("t5_wb_ready", 32'(wb_ready), 32'd1);
`ifdef RF_ARB_COALESCE_EN
        check("t5_dbg_ready", 32'(dbg_ready), 32'd1);
        tick();
        wb_valid = 1'b0; dbg_valid = 1'b0;
        check("t5_write_reg", 32'(write_reg), 32'd5);
        check("t5_write_data", 32'(write_data), 32'h11);
        tick();
        check("t5_single_write", 32'(regwrite), 32'd0);
`else
        check("t5_dbg_ready", 32'(dbg_ready), 32'd0);
        tick();
        wb_valid = 1'b0;
        check("t5_write_reg", 32'(write_reg), 32'd5);
        check("t5_write_data", 32'(write_data), 32'h11);
        #1 check("t5_dbg_ready2", 32'(dbg_ready), 32'd1);
        tick();
        dbg_valid = 1'b0;
        check("t5_regwrite2", 32'(regwrite), 32'd1);
        check("t5_write_data2", 32'(write_data), 32'h22);
        tick();
`endif

        // clear_dirty wins over a set in the same cycle
        wb_valid = 1'b1; wb_reg = 3'd0; wb_data = 8'h77;
        tick();
        wb_valid = 1'b0;
        check("t6_regwrite", 32'(regwrite), 32'd1);
        clear_dirty = 1'b1;
        tick();
        clear_dirty = 1'b0;
        check("t6_dirty", 32'(dirty), 32'h00);

        // asynchronous reset with a write in flight and a partly-built counter
        wb_valid = 1'b1; wb_reg = 3'd4; wb_data = 8'h5A;
        dbg_valid = 1'b1; dbg_reg = 3'd6; dbg_data = 8'h99;
        tick(); tick(); tick();
        check("t7_inflight", 32'(regwrite), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t7_async_regwrite", 32'(regwrite), 32'd0);
        check("t7_async_dirty", 32'(dirty), 32'h00);
        check("t7_async_write_reg", 32'(write_reg), 32'd0);
        check("t7_rst_wb_ready", 32'(wb_ready), 32'd1);
        #2 reset = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1 check($sformatf("t7_forced_c%0d", c), 32'(forced), 32'd0);
            tick();
        end
        #1 check("t7_forced_c5", 32'(forced), 32'd1);
        wb_valid = 1'b0; dbg_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
